// File: rtl/dcache_req_arb.sv
// ---------------------------------------------------------------------------
// dcache_req_arb
//
// Shares one multi-lane D-cache request/response port between NUM_REQS
// load/store requesters (for example the LSU and a prefetch engine).
// Requests are arbitrated round-robin at request granularity. A winner keeps
// the port until every active lane of its request has been accepted, so the
// cache may accept lanes piecemeal. The requester ID is appended in the tag
// LSBs on the way out and used to steer responses on the way back.
//
// Ports
//   clk, reset           clock and asynchronous active-low reset
//   in_req_*             per-requester, per-lane request fields (flattened,
//                        requester-major: index r*NUM_THREADS + t)
//   in_req_ready         per-requester, per-lane accept
//   mem_req_*            granted request towards the cache
//   mem_req_ready        cache per-lane ready
//   mem_rsp_*            cache response, tag carries the requester ID
//   out_rsp_*            per-requester response (tmask/data/tag broadcast)
//   out_rsp_ready        per-requester response accept
//   perf_stall_cnt       per-requester stall counters (DCACHE_ARB_PERF_EN)
//
// Optional feature macro: DCACHE_ARB_PERF_EN adds perf_stall_cnt.
// ---------------------------------------------------------------------------
module dcache_req_arb #(
   parameter int NUM_REQS      = 2,
   parameter int NUM_THREADS   = 4,
   parameter int TAG_IN_WIDTH  = 8,
   parameter int REQ_SEL_BITS  = $clog2(NUM_REQS),
   parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + REQ_SEL_BITS
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NUM_REQS*NUM_THREADS-1:0]            in_req_valid,
   input  logic [NUM_REQS*NUM_THREADS-1:0]            in_req_rw,
   input  logic [NUM_REQS*NUM_THREADS*4-1:0]          in_req_byteen,
   input  logic [NUM_REQS*NUM_THREADS*30-1:0]         in_req_addr,
   input  logic [NUM_REQS*NUM_THREADS*32-1:0]         in_req_data,
   input  logic [NUM_REQS*NUM_THREADS*TAG_IN_WIDTH-1:0] in_req_tag,
   output logic [NUM_REQS*NUM_THREADS-1:0]            in_req_ready,
   output logic [NUM_THREADS-1:0]                     mem_req_valid,
   output logic [NUM_THREADS-1:0]                     mem_req_rw,
   output logic [NUM_THREADS*4-1:0]                   mem_req_byteen,
   output logic [NUM_THREADS*30-1:0]                  mem_req_addr,
   output logic [NUM_THREADS*32-1:0]                  mem_req_data,
   output logic [NUM_THREADS*TAG_OUT_WIDTH-1:0]       mem_req_tag,
   input  logic [NUM_THREADS-1:0]                     mem_req_ready,
   input  logic                                       mem_rsp_valid,
   input  logic [NUM_THREADS-1:0]                     mem_rsp_tmask,
   input  logic [NUM_THREADS*32-1:0]                  mem_rsp_data,
   input  logic [TAG_OUT_WIDTH-1:0]                   mem_rsp_tag,
   output logic                                       mem_rsp_ready,
   output logic [NUM_REQS-1:0]                        out_rsp_valid,
   output logic [NUM_REQS*NUM_THREADS-1:0]            out_rsp_tmask,
   output logic [NUM_REQS*NUM_THREADS*32-1:0]         out_rsp_data,
   output logic [NUM_REQS*TAG_IN_WIDTH-1:0]           out_rsp_tag,
   input  logic [NUM_REQS-1:0]                        out_rsp_ready
`ifdef DCACHE_ARB_PERF_EN
   ,
   output logic [NUM_REQS*32-1:0]                     perf_stall_cnt
`endif
);

   if (NUM_REQS < 2) begin : g_num_reqs_check
      $error("dcache_req_arb: NUM_REQS must be at least 2");
   end

   typedef logic [REQ_SEL_BITS-1:0] sel_t;
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t state;
   sel_t   rr_ptr;
   sel_t   lock_id;

   sel_t   grant;
   sel_t   cand;
   logic   grant_found;
   logic   done;
   logic [NUM_REQS-1:0] active;

   logic [NUM_THREADS-1:0]              req_valid  [NUM_REQS];
   logic [NUM_THREADS-1:0]              req_rw     [NUM_REQS];
   logic [NUM_THREADS*4-1:0]            req_byteen [NUM_REQS];
   logic [NUM_THREADS*30-1:0]           req_addr   [NUM_REQS];
   logic [NUM_THREADS*32-1:0]           req_data   [NUM_REQS];
   logic [NUM_THREADS*TAG_IN_WIDTH-1:0] req_tag    [NUM_REQS];

   // Wrapping increment of a requester index.
   function automatic sel_t next_sel(input sel_t cur);
      if (int'(cur) == NUM_REQS - 1) begin
         return '0;
      end
      return cur + sel_t'(1);
   endfunction

   // Reshape the flat requester-major buses into per-requester arrays so the
   // grant can select a whole request with a single index.
   always_comb begin
      for (int r = 0; r < NUM_REQS; r++) begin
         req_valid[r]  = in_req_valid[r*NUM_THREADS +: NUM_THREADS];
         req_rw[r]     = in_req_rw[r*NUM_THREADS +: NUM_THREADS];
         req_byteen[r] = in_req_byteen[r*NUM_THREADS*4 +: NUM_THREADS*4];
         req_addr[r]   = in_req_addr[r*NUM_THREADS*30 +: NUM_THREADS*30];
         req_data[r]   = in_req_data[r*NUM_THREADS*32 +: NUM_THREADS*32];
         req_tag[r]    = in_req_tag[r*NUM_THREADS*TAG_IN_WIDTH +: NUM_THREADS*TAG_IN_WIDTH];
         active[r]     = |req_valid[r];
      end
   end

   // Grant selection. While locked the owner keeps the port even if it has
   // momentarily nothing valid (that simply reads as done and releases).
   // In IDLE the search walks downwards so the candidate nearest rr_ptr is
   // the last one written and therefore wins.
   always_comb begin
      grant       = '0;
      cand        = '0;
      grant_found = 1'b0;
      if (state == LOCKED) begin
         grant       = lock_id;
         grant_found = 1'b1;
      end else begin
         for (int k = NUM_REQS - 1; k >= 0; k--) begin
            cand = sel_t'((int'(rr_ptr) + k) % NUM_REQS);
            if (active[cand]) begin
               grant       = cand;
               grant_found = 1'b1;
            end
         end
      end
   end

   // Forward the granted request; the requester ID rides in the tag LSBs.
   always_comb begin
      mem_req_valid  = grant_found ? req_valid[grant] : '0;
      mem_req_rw     = req_rw[grant];
      mem_req_byteen = req_byteen[grant];
      mem_req_addr   = req_addr[grant];
      mem_req_data   = req_data[grant];
      for (int t = 0; t < NUM_THREADS; t++) begin
         mem_req_tag[t*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] =
            {req_tag[grant][t*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant};
      end
      for (int r = 0; r < NUM_REQS; r++) begin
         in_req_ready[r*NUM_THREADS +: NUM_THREADS] =
            (grant_found && (grant == sel_t'(r))) ? mem_req_ready : '0;
      end
   end

   // The request completes once no valid lane is left unaccepted this cycle.
   assign done = &(~mem_req_valid | mem_req_ready);

   // Arbitration FSM: a partially accepted request locks the port to its
   // owner; completion moves the round-robin pointer past the winner.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  if (done) begin
                     rr_ptr <= next_sel(grant);
                  end else begin
                     state   <= LOCKED;
                     lock_id <= grant;
                  end
               end
            end
            LOCKED: begin
               if (done) begin
                  state  <= IDLE;
                  rr_ptr <= next_sel(lock_id);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_ARB_PERF_EN
   logic [31:0] stall_cnt [NUM_REQS];

   // A requester stalls on every cycle it has work but does not own the port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REQS; r++) begin
            stall_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REQS; r++) begin
            if (active[r] && !(grant_found && (grant == sel_t'(r)))) begin
               stall_cnt[r] <= stall_cnt[r] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REQS; r++) begin
         perf_stall_cnt[r*32 +: 32] = stall_cnt[r];
      end
   end
`endif

   // Response demux: the tag LSBs name the requester. An ID beyond
   // NUM_REQS can only come from a corrupted tag; it is swallowed.
   sel_t rsp_id;
   logic rsp_id_ok;

   assign rsp_id    = mem_rsp_tag[REQ_SEL_BITS-1:0];
   assign rsp_id_ok = (int'(rsp_id) < NUM_REQS);

   always_comb begin
      out_rsp_valid = '0;
      mem_rsp_ready = 1'b1;
      if (rsp_id_ok) begin
         out_rsp_valid[rsp_id] = mem_rsp_valid;
         mem_rsp_ready         = out_rsp_ready[rsp_id];
      end
   end

   assign out_rsp_tmask = {NUM_REQS{mem_rsp_tmask}};
   assign out_rsp_data  = {NUM_REQS{mem_rsp_data}};
   assign out_rsp_tag   = {NUM_REQS{mem_rsp_tag[TAG_OUT_WIDTH-1:REQ_SEL_BITS]}};

   rsp_id_in_range: assert property (@(posedge clk) disable iff (!reset)
                                     mem_rsp_valid |-> rsp_id_ok);

endmodule

// File: tb/tb_dcache_req_arb.sv
// ---------------------------------------------------------------------------
// tb_dcache_req_arb
//
// Self-checking bench for dcache_req_arb with NUM_REQS=2, NUM_THREADS=4.
// A behavioural model (owner / round-robin pointer kept as plain integers)
// predicts every output each cycle; a few directed scenarios add literal
// expectations on top. Inputs change 1 time unit after the rising edge and
// outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_dcache_req_arb;

   localparam int NR  = 2;
   localparam int NT  = 4;
   localparam int TW  = 8;
   localparam int SB  = 1;
   localparam int TOW = TW + SB;

   logic                clk = 1'b0;
   logic                reset;
   logic [NR*NT-1:0]    in_req_valid;
   logic [NR*NT-1:0]    in_req_rw;
   logic [NR*NT*4-1:0]  in_req_byteen;
   logic [NR*NT*30-1:0] in_req_addr;
   logic [NR*NT*32-1:0] in_req_data;
   logic [NR*NT*TW-1:0] in_req_tag;
   logic [NR*NT-1:0]    in_req_ready;
   logic [NT-1:0]       mem_req_valid;
   logic [NT-1:0]       mem_req_rw;
   logic [NT*4-1:0]     mem_req_byteen;
   logic [NT*30-1:0]    mem_req_addr;
   logic [NT*32-1:0]    mem_req_data;
   logic [NT*TOW-1:0]   mem_req_tag;
   logic [NT-1:0]       mem_req_ready;
   logic                mem_rsp_valid;
   logic [NT-1:0]       mem_rsp_tmask;
   logic [NT*32-1:0]    mem_rsp_data;
   logic [TOW-1:0]      mem_rsp_tag;
   logic                mem_rsp_ready;
   logic [NR-1:0]       out_rsp_valid;
   logic [NR*NT-1:0]    out_rsp_tmask;
   logic [NR*NT*32-1:0] out_rsp_data;
   logic [NR*TW-1:0]    out_rsp_tag;
   logic [NR-1:0]       out_rsp_ready;
`ifdef DCACHE_ARB_PERF_EN
   logic [NR*32-1:0]    perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   dcache_req_arb #(
      .NUM_REQS     (NR),
      .NUM_THREADS  (NT),
      .TAG_IN_WIDTH (TW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_req_valid   (in_req_valid),
      .in_req_rw      (in_req_rw),
      .in_req_byteen  (in_req_byteen),
      .in_req_addr    (in_req_addr),
      .in_req_data    (in_req_data),
      .in_req_tag     (in_req_tag),
      .in_req_ready   (in_req_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_rw     (mem_req_rw),
      .mem_req_byteen (mem_req_byteen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_tag    (mem_req_tag),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_tmask  (mem_rsp_tmask),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_tag    (mem_rsp_tag),
      .mem_rsp_ready  (mem_rsp_ready),
      .out_rsp_valid  (out_rsp_valid),
      .out_rsp_tmask  (out_rsp_tmask),
      .out_rsp_data   (out_rsp_data),
      .out_rsp_tag    (out_rsp_tag),
      .out_rsp_ready  (out_rsp_ready)
`ifdef DCACHE_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model state: current port owner (-1 = nobody holds the port) and the
   // requester that round-robin search starts from.
   int          m_owner;
   int          m_rr;
   logic [31:0] m_perf [NR];
   logic [NR*NT-1:0] fired;

   task automatic check_vec(input string name, input logic [255:0] act,
                            input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Who owns the port this cycle according to the arbitration rules.
   function automatic int model_grant();
      int r;
      if (m_owner >= 0) return m_owner;
      for (int k = 0; k < NR; k++) begin
         r = (m_rr + k) % NR;
         if (in_req_valid[r*NT +: NT] != '0) return r;
      end
      return -1;
   endfunction

   task automatic checkOutput();
      int               g;
      int               id;
      logic [NT-1:0]    ev;
      logic [NT-1:0]    erw;
      logic [NT*4-1:0]  ebe;
      logic [NT*30-1:0] ead;
      logic [NT*32-1:0] edat;
      logic [NT*TOW-1:0] etag;
      logic [NR*NT-1:0] erdy;
      logic [NR-1:0]    ervalid;
      g    = model_grant();
      ev   = '0;
      erw  = '0;
      ebe  = '0;
      ead  = '0;
      edat = '0;
      etag = '0;
      erdy = '0;
      if (g >= 0) begin
         for (int t = 0; t < NT; t++) begin
            ev[t]             = in_req_valid[g*NT + t];
            erw[t]            = in_req_rw[g*NT + t];
            ebe[t*4 +: 4]     = in_req_byteen[(g*NT + t)*4 +: 4];
            ead[t*30 +: 30]   = in_req_addr[(g*NT + t)*30 +: 30];
            edat[t*32 +: 32]  = in_req_data[(g*NT + t)*32 +: 32];
            etag[t*TOW +: TOW] = {in_req_tag[(g*NT + t)*TW +: TW], g[SB-1:0]};
         end
         erdy[g*NT +: NT] = mem_req_ready;
      end
      check_vec("mem_req_valid", 256'(mem_req_valid), 256'(ev));
      if (g >= 0) begin
         check_vec("mem_req_rw", 256'(mem_req_rw), 256'(erw));
         check_vec("mem_req_byteen", 256'(mem_req_byteen), 256'(ebe));
         check_vec("mem_req_addr", 256'(mem_req_addr), 256'(ead));
         check_vec("mem_req_data", 256'(mem_req_data), 256'(edat));
         check_vec("mem_req_tag", 256'(mem_req_tag), 256'(etag));
      end
      check_vec("in_req_ready", 256'(in_req_ready), 256'(erdy));

      id = int'(mem_rsp_tag[SB-1:0]);
      ervalid     = '0;
      ervalid[id] = mem_rsp_valid;
      check_vec("out_rsp_valid", 256'(out_rsp_valid), 256'(ervalid));
      check_vec("mem_rsp_ready", 256'(mem_rsp_ready), 256'(out_rsp_ready[id]));
      check_vec("out_rsp_tmask", 256'(out_rsp_tmask), 256'({NR{mem_rsp_tmask}}));
      check_vec("out_rsp_data", 256'(out_rsp_data), 256'({NR{mem_rsp_data}}));
      check_vec("out_rsp_tag", 256'(out_rsp_tag), 256'({NR{mem_rsp_tag[TOW-1:SB]}}));
`ifdef DCACHE_ARB_PERF_EN
      for (int r = 0; r < NR; r++) begin
         check_vec("perf_stall_cnt", 256'(perf_stall_cnt[r*32 +: 32]), 256'(m_perf[r]));
      end
`endif
   endtask

   // Advance the model across one rising edge using this cycle's inputs.
   task automatic model_advance();
      int            g;
      logic [NT-1:0] gv;
      g     = model_grant();
      fired = '0;
      for (int r = 0; r < NR; r++) begin
         if (r != g && in_req_valid[r*NT +: NT] != '0) m_perf[r] = m_perf[r] + 32'd1;
      end
      if (g >= 0) begin
         gv = in_req_valid[g*NT +: NT];
         fired[g*NT +: NT] = gv & mem_req_ready;
         if ((gv & ~mem_req_ready) == '0) begin
            m_owner = -1;
            m_rr    = (g + 1) % NR;
         end else begin
            m_owner = g;
         end
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_rr    = 0;
      for (int r = 0; r < NR; r++) m_perf[r] = '0;
      fired   = '0;
   endtask

   task automatic sample();
      @(negedge clk);
      checkOutput();
   endtask

   // Requesters drop exactly the lanes that fired.
   task automatic finish_cycle();
      model_advance();
      @(posedge clk);
      #1;
      in_req_valid = in_req_valid & ~fired;
   endtask

   task automatic run_cycle();
      sample();
      finish_cycle();
   endtask

   task automatic clear_inputs();
      in_req_valid  = '0;
      in_req_rw     = '0;
      in_req_byteen = '0;
      in_req_addr   = '0;
      in_req_data   = '0;
      in_req_tag    = '0;
      mem_req_ready = '0;
      mem_rsp_valid = 1'b0;
      mem_rsp_tmask = '0;
      mem_rsp_data  = '0;
      mem_rsp_tag   = '0;
      out_rsp_ready = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic fill_fields(input int r);
      for (int t = 0; t < NT; t++) begin
         in_req_rw[r*NT + t]                = 1'($urandom_range(0, 1));
         in_req_byteen[(r*NT + t)*4 +: 4]   = 4'($urandom_range(0, 15));
         in_req_addr[(r*NT + t)*30 +: 30]   = 30'($urandom);
         in_req_data[(r*NT + t)*32 +: 32]   = $urandom;
         in_req_tag[(r*NT + t)*TW +: TW]    = 8'($urandom_range(0, 255));
      end
   endtask

   // Random traffic honouring the requester contract: a new request only
   // starts once the previous one has fully fired.
   task automatic applyStimulus();
      for (int r = 0; r < NR; r++) begin
         if (in_req_valid[r*NT +: NT] == '0 && $urandom_range(0, 2) != 0) begin
            fill_fields(r);
            in_req_valid[r*NT +: NT] = 4'($urandom_range(1, 15));
         end
      end
      mem_req_ready = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_tmask = 4'($urandom_range(0, 15));
      for (int t = 0; t < NT; t++) mem_rsp_data[t*32 +: 32] = $urandom;
      mem_rsp_tag   = 9'($urandom_range(0, 511));
      out_rsp_ready = 2'($urandom_range(0, 3));
   endtask

   initial begin
      reset = 1'b0;
      model_reset();
      clear_inputs();
      #1;
      checkOutput();
      check_vec("reset_mem_req_valid", 256'(mem_req_valid), 256'h0);
      check_vec("reset_out_rsp_valid", 256'(out_rsp_valid), 256'h0);
      do_reset();

      $display("[TB] fairness");
      for (int i = 0; i < 2; i++) fill_fields(i);
      in_req_valid  = 8'hFF;
      mem_req_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         sample();
         check_vec("fair_ready", 256'(in_req_ready), (i % 2 == 0) ? 256'h0F : 256'hF0);
         check_vec("fair_tag_lsb", 256'(mem_req_tag[0]), 256'(i % 2));
         finish_cycle();
         in_req_valid = 8'hFF;
      end

      $display("[TB] partial accept lock");
      do_reset();
      for (int i = 0; i < 2; i++) fill_fields(i);
      in_req_valid  = 8'hFF;
      mem_req_ready = 4'b0011;
      sample();
      check_vec("lock_c1_ready", 256'(in_req_ready), 256'h03);
      finish_cycle();
      mem_req_ready = 4'b1100;
      sample();
      check_vec("lock_c2_ready", 256'(in_req_ready), 256'h0C);
      finish_cycle();
      mem_req_ready = 4'hF;
      sample();
      check_vec("lock_c3_ready", 256'(in_req_ready), 256'hF0);
      finish_cycle();

      $display("[TB] single requester and response routing");
      do_reset();
      fill_fields(1);
      in_req_valid  = 8'hF0;
      mem_req_ready = 4'hF;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = {8'hA5, 1'b1};
      mem_rsp_tmask = 4'b0101;
      out_rsp_ready = 2'b10;
      sample();
      check_vec("single_ready", 256'(in_req_ready), 256'hF0);
      check_vec("single_tag_lsb", 256'(mem_req_tag[0]), 256'h1);
      check_vec("rsp_valid", 256'(out_rsp_valid), 256'h2);
      check_vec("rsp_tag1", 256'(out_rsp_tag[15:8]), 256'hA5);
      check_vec("rsp_ready_hi", 256'(mem_rsp_ready), 256'h1);
      out_rsp_ready = 2'b01;
      #1;
      check_vec("rsp_ready_lo", 256'(mem_rsp_ready), 256'h0);
      finish_cycle();
      mem_rsp_valid = 1'b0;

      $display("[TB] async reset while locked");
      do_reset();
      fill_fields(0);
      fill_fields(1);
      in_req_valid  = 8'hF0;
      mem_req_ready = 4'h0;
      run_cycle();
      in_req_valid  = 8'hFF;
      mem_req_ready = 4'hF;
      sample();
      check_vec("locked1_ready", 256'(in_req_ready), 256'hF0);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      checkOutput();
      check_vec("reset_idle_ready", 256'(in_req_ready), 256'h0F);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      sample();
      check_vec("post_reset_ready", 256'(in_req_ready), 256'h0F);
      finish_cycle();

`ifdef DCACHE_ARB_PERF_EN
      $display("[TB] stall counters");
      do_reset();
      fill_fields(0);
      fill_fields(1);
      in_req_valid  = 8'hFF;
      mem_req_ready = 4'h0;
      repeat (4) run_cycle();
      mem_req_ready = 4'hF;
      run_cycle();
      in_req_valid = in_req_valid & 8'hF0;
      sample();
      check_vec("perf_req1", 256'(perf_stall_cnt[63:32]), 256'd5);
      check_vec("perf_req0", 256'(perf_stall_cnt[31:0]), 256'd0);
      finish_cycle();
`endif

      $display("[TB] random traffic");
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_req_arb.md
Name: dcache_req_arb

Overview:
- Shares one per-thread D-cache request/response port between NUM_REQS load/store requesters, e.g. the LSU plus a prefetch or texture fetch engine.
- Round-robin arbitration at request granularity.
- Once a requester wins, it keeps the port until every active lane of its request has been accepted. This allows partial per-lane acceptance.
- Appends the requester ID to the tag and demultiplexes responses back to the requester by tag.

Parameters:
- NUM_REQS, 2: number of requesters. Must be ≥2 (static assert).
- NUM_THREADS, 4: lanes per request.
- TAG_IN_WIDTH, 8: requester-side tag width.
- REQ_SEL_BITS, CLOG2(NUM_REQS): derived. Width of the requester ID.
- TAG_OUT_WIDTH, TAG_IN_WIDTH+REQ_SEL_BITS: derived. Cache-side tag width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_req_valid  in  NUM_REQS*NUM_THREADS  per-requester, per-lane request valid
- in_req_rw  in  NUM_REQS*NUM_THREADS  1=write
- in_req_byteen  in  NUM_REQS*NUM_THREADS*4  byte enables
- in_req_addr  in  NUM_REQS*NUM_THREADS*30  word address
- in_req_data  in  NUM_REQS*NUM_THREADS*32  write data
- in_req_tag  in  NUM_REQS*NUM_THREADS*TAG_IN_WIDTH  request tag
- in_req_ready  out  NUM_REQS*NUM_THREADS  per-lane accept
- mem_req_valid/rw/byteen/addr/data  out  NUM_THREADS*(1/1/4/30/32)  granted request
- mem_req_tag  out  NUM_THREADS*TAG_OUT_WIDTH  {in_tag, req_id}
- mem_req_ready  in  NUM_THREADS  cache per-lane ready
- mem_rsp_valid  in  1  response valid
- mem_rsp_tmask  in  NUM_THREADS  response lanes
- mem_rsp_data  in  NUM_THREADS*32  response data
- mem_rsp_tag  in  TAG_OUT_WIDTH  response tag
- mem_rsp_ready  out  1  response accept
- out_rsp_valid  out  NUM_REQS  per-requester response valid
- out_rsp_tmask  out  NUM_REQS*NUM_THREADS  response lanes
- out_rsp_data  out  NUM_REQS*NUM_THREADS*32  response data
- out_rsp_tag  out  NUM_REQS*TAG_IN_WIDTH  response tag, requester-side
- out_rsp_ready  in  NUM_REQS  requester accepts response

Behaviour:

Reset:
- Asserting reset (low) asynchronously forces state=IDLE, rr_ptr=0, lock_id=0.
- All outputs are combinational from state and inputs. With no input valid, every valid output is 0.

Requester activity:
- Requester r is active when OR of its in_req_valid lanes = 1.

State IDLE:
- grant = first active requester searching rr_ptr, rr_ptr+1, … modulo NUM_REQS.
- If no requester is active, grant=none and mem_req_valid=0.

State LOCKED:
- grant = lock_id, regardless of other requesters.

Forwarding:
- mem_req_* = fields of the granted requester.
- mem_req_tag[t] = {in_req_tag[grant][t], grant[REQ_SEL_BITS-1:0]}. The ID occupies the LSBs.
- in_req_ready[r][t] = (r==grant) & mem_req_ready[t]. Non-granted requesters see 0.

Completion:
- done = every valid lane of the granted requester is accepted this cycle, i.e. AND over t of (~valid[t] | mem_req_ready[t]).
- IDLE, active, done: stay IDLE; rr_ptr <= grant+1 (wrap).
- IDLE, active, not done: go to LOCKED; lock_id <= grant.
- LOCKED, done: go to IDLE; rr_ptr <= lock_id+1 (wrap).
- LOCKED, not done: hold.

Requester contract:
- A requester drops a lane's valid only after that lane fires.
- It keeps unfired lanes stable.
- In LOCKED, if the locked requester deasserts all of its lanes, done=1 and the FSM returns to IDLE.

Latency:
- Request path has zero cycles of added latency, combinational.
- Response path has zero cycles of added latency.

Responses:
- id = mem_rsp_tag[REQ_SEL_BITS-1:0].
- out_rsp_valid[id] = mem_rsp_valid; all other out_rsp_valid bits = 0.
- tmask and data are broadcast to all requesters.
- out_rsp_tag[r] = mem_rsp_tag[TAG_OUT_WIDTH-1:REQ_SEL_BITS].
- mem_rsp_ready = out_rsp_ready[id].
- id ≥ NUM_REQS (possible only for non-power-of-2 NUM_REQS): simulation assertion fires; response is dropped with mem_rsp_ready=1.

Simultaneous events:
- A response and a request in the same cycle are independent.
- A new requester becoming active while LOCKED waits; it is not starved beyond one request per other requester.

Optional Feature:
- Macro: DCACHE_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt, width NUM_REQS*32.
  - Counter r increments each cycle that requester r is active and grant≠r.
  - The counter wraps modulo 2^32.
  - Counters clear on reset.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
1. Fairness:
   - Stimulus: NUM_REQS=2, both requesters hold lanes 0–3 valid continuously, mem_req_ready=4'hF.
   - Required: grants alternate 0,1,0,1; each request fires in 1 cycle; mem_req_tag LSB alternates 0/1.
2. Partial-accept lock:
   - Stimulus: requester 0 wins with 4 lanes; mem_req_ready=4'b0011, then 4'b1100 on the next cycle; requester 1 is active throughout.
   - Required: state LOCKED for one cycle with lock_id=0; requester 1 not granted until cycle 3; rr_ptr=1 afterward.
3. Response routing:
   - Stimulus: mem_rsp_tag={8'hA5,1'b1}, valid=1, tmask=4'b0101, out_rsp_ready=2'b10.
   - Required: out_rsp_valid=2'b10, out_rsp_tag[1]=8'hA5, mem_rsp_ready=1. Repeat with out_rsp_ready=2'b01: mem_rsp_ready=0.
4. Single requester:
   - Stimulus: only requester 1 active, rr_ptr=0.
   - Required: grant=1 in the same cycle; requester 0 in_req_ready=0.
5. Async reset mid-lock:
   - Stimulus: drive reset low while LOCKED with lock_id=1.
   - Required: mem_req_valid follows IDLE arbitration immediately (before the next clk edge); after release, the first grant searches from requester 0.
6. Perf counter (DCACHE_ARB_PERF_EN):
   - Stimulus: requester 1 blocked by a 5-cycle lock held by requester 0.
   - Required: perf_stall_cnt[1]=5, perf_stall_cnt[0]=0.
